bv_gen: RTL and testbench
=========================

Name: bv_gen

Overview:
- Builds a width-bit rule bit vector from a framed stream of rule indices.
- Writer-side counterpart of the bv_count pipeline: bv_count consumes a bit vector and produces a rule index; bv_gen consumes rule indices and produces the bit vector.
- Used by the bv2.0_programmable control path to assemble per-field match vectors before they are loaded into the lookup tables.
- Framed input with sop/eop; single-entry output with valid/ready handshake.

Parameters:
- width, 64, bit-vector width (number of rules).
- width_count, 6, rule-index width; 2**width_count >= width.

Ports:
- clk  input  1  clock.
- reset  input  1  one clock; reset is synchronous and active-low.
- idx_valid  input  1  index beat valid.
- idx_sop  input  1  first beat of a vector frame.
- idx_eop  input  1  last beat of a vector frame (may coincide with sop).
- idx  input  width_count  rule index to set.
- idx_ready  output  1  block accepts an index beat this cycle.
- bv_out_valid  output  1  completed vector available.
- bv_out_ready  input  1  downstream consumes the vector.
- bv_out  output  width  assembled vector; bit i set if index i was received.
- num_out  output  width_count+1  number of distinct bits set in bv_out.
- err_out  output  1  frame contained an index >= width.
- proto_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- A beat is accepted when idx_valid & idx_ready.
- FSM states: IDLE, ACCUM, HOLD.
- idx_ready is 1 in IDLE and ACCUM and 0 in HOLD. It is 0 while reset is asserted.
- Reset (reset==0 at posedge):
  - state goes to IDLE;
  - accumulator, bv_out, num_out, err_out, bv_out_valid and proto_err are all cleared;
  - any frame in progress or any held vector is discarded.
- IDLE:
  - Accepted beat with sop: acc = onehot(idx), num = 1, err = (idx>=width). Go to HOLD if eop, else ACCUM.
  - Accepted beat without sop: dropped, proto_err pulses next cycle, stay in IDLE.
- ACCUM:
  - Accepted beat without sop: acc |= onehot(idx). num increments only if that bit was previously 0. err |= (idx>=width).
  - Accepted beat with sop: frame restarts exactly as in IDLE, and proto_err pulses.
  - eop on an accepted beat: go to HOLD.
- HOLD:
  - bv_out_valid = 1; bv_out, num_out and err_out are stable.
  - On bv_out_ready: bv_out_valid drops next cycle, outputs return to 0, state goes to IDLE.
  - No new beat is accepted in the cycle the vector is consumed. idx_ready rises the following cycle.
- Latency: eop accepted at cycle N gives bv_out_valid=1 at N+1. bv_out_ready at N+1 gives idx_ready=1 at N+2.
- Out-of-range index (idx >= width):
  - no bit is set and num is unchanged;
  - err_out=1 is presented with the vector.
- Duplicate index: the bit stays set and num is not incremented.
- Full vector: num_out = width (needs width_count+1 bits). No wrap.
- While bv_out_valid==0, bv_out, num_out and err_out are 0.
- proto_err is registered, exactly one cycle per violation, and otherwise 0.

Optional Feature:
- Macro BV_GEN_LOWEST_EN.
- Defined:
  - adds output low_out [width_count-1:0], the lowest index set in bv_out, valid with bv_out_valid;
  - tracked incrementally as a running minimum of accepted in-range indices, one compare per beat;
  - low_out is 0 when no in-range index was received, and 0 whenever bv_out_valid==0;
  - downstream can use low_out to seed bv_count's count input directly.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Frame of indices 3 (sop), 0, 63 (eop), then bv_out_ready=1 -> bv_out=64'h8000_0000_0000_0009, num_out=3, err_out=0, bv_out_valid high 1 cycle after eop; with BV_GEN_LOWEST_EN, low_out=0.
- Single beat with sop=eop=1, idx=5 -> next cycle bv_out=64'h20, num_out=1. Hold bv_out_ready=0 for 4 cycles -> idx_ready=0 and outputs stable throughout, then ready=1 -> valid drops, idx_ready=1 one cycle later.
- Frame 7 (sop), 7, 7 (eop) -> bv_out=64'h80, num_out=1.
- width=48 build, frame 2 (sop), 50 (eop) -> bv_out=48'h4, num_out=1, err_out=1.
- Beat without sop in IDLE -> proto_err pulses 1 cycle and no vector is produced. Frame 1 (sop), 2, then 9 (sop, eop) -> proto_err pulse, bv_out=64'h200, num_out=1.
- reset=0 mid-frame after indices 4, 6, then a clean frame 10 (sop/eop) -> bv_out=64'h400, num_out=1. All 64 indices in one frame -> bv_out all ones, num_out=64.

Source files
------------

// File: rtl/bv_gen.sv
`default_nettype none
// ============================================================================
// Module   : bv_gen
// Brief    : Assembles a rule bit vector from a framed stream of rule indices
//            and presents it with a valid/ready handshake. Define
//            BV_GEN_LOWEST_EN to add low_out, the lowest index set.
// Revision : 1.0 - initial release
// ============================================================================
module bv_gen #(
    parameter int width       = 64,
    parameter int width_count = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   idx_valid,
    input  logic                   idx_sop,
    input  logic                   idx_eop,
    input  logic [width_count-1:0] idx,
    output logic                   idx_ready,
    output logic                   bv_out_valid,
    input  logic                   bv_out_ready,
    output logic [width-1:0]       bv_out,
    output logic [width_count:0]   num_out,
    output logic                   err_out,
    output logic                   proto_err
`ifdef BV_GEN_LOWEST_EN
    ,
    output logic [width_count-1:0] low_out
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [width_count:0] c_width = (width_count+1)'(width);
    localparam logic [width-1:0]     c_one   = {{(width-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [width-1:0]       r_acc;
    logic [width_count:0]   r_num;
    logic                   r_err;
    logic                   r_proto_err;

    logic                   w_accept;
    logic                   w_in_range;
    logic [width-1:0]       w_onehot;
    logic                   w_new_bit;

`ifdef BV_GEN_LOWEST_EN
    logic [width_count-1:0] r_low;
    logic                   r_low_vld;
`endif

    assign idx_ready  = reset & (r_state != S_HOLD);
    assign w_accept   = idx_valid & idx_ready;
    assign w_in_range = {1'b0, idx} < c_width;
    assign w_onehot   = w_in_range ? (c_one << idx) : '0;
    // A duplicate index leaves the vector unchanged, so no count increment.
    assign w_new_bit  = |(w_onehot & ~r_acc);

    assign bv_out_valid = (r_state == S_HOLD);
    assign bv_out       = bv_out_valid ? r_acc : '0;
    assign num_out      = bv_out_valid ? r_num : '0;
    assign err_out      = bv_out_valid & r_err;
    assign proto_err    = r_proto_err;
`ifdef BV_GEN_LOWEST_EN
    assign low_out      = bv_out_valid ? r_low : '0;
`endif

    always_ff @(posedge clk) begin
        r_proto_err <= 1'b0;
        if (!reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_num   <= '0;
            r_err   <= 1'b0;
`ifdef BV_GEN_LOWEST_EN
            r_low     <= '0;
            r_low_vld <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        if (idx_sop) begin
                            r_acc <= w_onehot;
                            r_num <= w_in_range ? (width_count+1)'(1) : '0;
                            r_err <= ~w_in_range;
`ifdef BV_GEN_LOWEST_EN
                            r_low     <= w_in_range ? idx : '0;
                            r_low_vld <= w_in_range;
`endif
                            r_state     <= idx_eop ? S_HOLD : S_ACCUM;
                            r_proto_err <= (r_state == S_ACCUM);
                        end else if (r_state == S_ACCUM) begin
                            r_acc <= r_acc | w_onehot;
                            if (w_new_bit)
                                r_num <= r_num + 1'b1;
                            r_err <= r_err | ~w_in_range;
`ifdef BV_GEN_LOWEST_EN
                            if (w_in_range && (!r_low_vld || idx < r_low)) begin
                                r_low     <= idx;
                                r_low_vld <= 1'b1;
                            end
`endif
                            if (idx_eop)
                                r_state <= S_HOLD;
                        end else begin
                            // Orphan beat outside a frame is dropped.
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bv_out_ready) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_num   <= '0;
                        r_err   <= 1'b0;
`ifdef BV_GEN_LOWEST_EN
                        r_low     <= '0;
                        r_low_vld <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bv_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bv_gen
// Brief    : Directed self-checking bench for bv_gen (64-rule and 48-rule
//            instances sharing the index bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bv_gen;

    logic        clk;
    logic        reset;
    logic        v64;
    logic        v48;
    logic        sop;
    logic        eop;
    logic [5:0]  idx;
    logic        ready;

    logic        rdy64, val64, err64, perr64;
    logic [63:0] bv64;
    logic [6:0]  num64;
    logic        rdy48, val48, err48, perr48;
    logic [47:0] bv48;
    logic [6:0]  num48;
`ifdef BV_GEN_LOWEST_EN
    logic [5:0]  low64;
    logic [5:0]  low48;
`endif

    int n_vec;
    int n_err;

    bv_gen #(.width(64), .width_count(6)) dut (
        .clk(clk), .reset(reset), .idx_valid(v64), .idx_sop(sop), .idx_eop(eop),
        .idx(idx), .idx_ready(rdy64), .bv_out_valid(val64), .bv_out_ready(ready),
        .bv_out(bv64), .num_out(num64), .err_out(err64), .proto_err(perr64)
`ifdef BV_GEN_LOWEST_EN
        , .low_out(low64)
`endif
    );

    bv_gen #(.width(48), .width_count(6)) dut48 (
        .clk(clk), .reset(reset), .idx_valid(v48), .idx_sop(sop), .idx_eop(eop),
        .idx(idx), .idx_ready(rdy48), .bv_out_valid(val48), .bv_out_ready(ready),
        .bv_out(bv48), .num_out(num48), .err_out(err48), .proto_err(perr48)
`ifdef BV_GEN_LOWEST_EN
        , .low_out(low48)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One beat on the 64-rule (sel=0) or 48-rule (sel=1) instance.
    task automatic beat(input bit sel, input bit s, input bit e, input int i);
        sop = s;
        eop = e;
        idx = 6'(i);
        if (sel) v48 = 1'b1; else v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        v48 = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
    endtask

    task automatic consume(input string tag);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(val64), 64'd0);
        chk({tag, "_bv_zero"},    bv64, 64'd0);
        chk({tag, "_num_zero"},   64'(num64), 64'd0);
        chk({tag, "_rdy_back"},   64'(rdy64), 64'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        v64 = 1'b0; v48 = 1'b0; sop = 1'b0; eop = 1'b0; idx = '0; ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(val64), 64'd0);
        chk("rst_ready", 64'(rdy64), 64'd0);
        chk("rst_bv",    bv64, 64'd0);
        chk("rst_perr",  64'(perr64), 64'd0);
        reset = 1'b1;
        #1;
        chk("idle_ready", 64'(rdy64), 64'd1);

        // 3, 0, 63
        beat(0, 1, 0, 3);
        beat(0, 0, 0, 0);
        chk("f1_not_yet", 64'(val64), 64'd0);
        beat(0, 0, 1, 63);
        chk("f1_valid", 64'(val64), 64'd1);
        chk("f1_bv",    bv64, 64'h8000_0000_0000_0009);
        chk("f1_num",   64'(num64), 64'd3);
        chk("f1_err",   64'(err64), 64'd0);
        chk("f1_rdy",   64'(rdy64), 64'd0);
`ifdef BV_GEN_LOWEST_EN
        chk("f1_low",   64'(low64), 64'd0);
`endif
        consume("f1");

        // single beat 5, held for four cycles with a beat offered meanwhile
        beat(0, 1, 1, 5);
        chk("f2_bv",  bv64, 64'h20);
        chk("f2_num", 64'(num64), 64'd1);
        v64 = 1'b1; sop = 1'b1; eop = 1'b1; idx = 6'd9;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("f2_hold_rdy", 64'(rdy64), 64'd0);
            chk("f2_hold_bv",  bv64, 64'h20);
            chk("f2_hold_val", 64'(val64), 64'd1);
        end
        v64 = 1'b0; sop = 1'b0; eop = 1'b0;
`ifdef BV_GEN_LOWEST_EN
        chk("f2_low", 64'(low64), 64'd5);
`endif
        consume("f2");

        // duplicates 7, 7, 7
        beat(0, 1, 0, 7);
        beat(0, 0, 0, 7);
        beat(0, 0, 1, 7);
        chk("f3_bv",  bv64, 64'h80);
        chk("f3_num", 64'(num64), 64'd1);
`ifdef BV_GEN_LOWEST_EN
        chk("f3_low", 64'(low64), 64'd7);
`endif
        consume("f3");

        // 48-rule instance: 2, 50 (out of range)
        beat(1, 1, 0, 2);
        beat(1, 0, 1, 50);
        chk("f4_valid", 64'(val48), 64'd1);
        chk("f4_bv",    64'(bv48), 64'h4);
        chk("f4_num",   64'(num48), 64'd1);
        chk("f4_err",   64'(err48), 64'd1);
`ifdef BV_GEN_LOWEST_EN
        chk("f4_low",   64'(low48), 64'd2);
`endif
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("f4_drop", 64'(val48), 64'd0);
        chk("f4_err0", 64'(err48), 64'd0);

        // orphan beat in IDLE
        beat(0, 0, 0, 3);
        chk("p1_perr",  64'(perr64), 64'd1);
        chk("p1_noval", 64'(val64), 64'd0);
        @(posedge clk); #1;
        chk("p1_perr_off", 64'(perr64), 64'd0);
        chk("p1_noval2",   64'(val64), 64'd0);

        // restart mid-frame: 1, 2, then 9 with sop/eop
        beat(0, 1, 0, 1);
        beat(0, 0, 0, 2);
        chk("p2_noperr", 64'(perr64), 64'd0);
        beat(0, 1, 1, 9);
        chk("p2_perr",  64'(perr64), 64'd1);
        chk("p2_valid", 64'(val64), 64'd1);
        chk("p2_bv",    bv64, 64'h200);
        chk("p2_num",   64'(num64), 64'd1);
        @(posedge clk); #1;
        chk("p2_perr_off", 64'(perr64), 64'd0);
        consume("p2");

        // reset mid-frame
        beat(0, 1, 0, 4);
        beat(0, 0, 0, 6);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("r_valid", 64'(val64), 64'd0);
        chk("r_rdy",   64'(rdy64), 64'd0);
        reset = 1'b1;
        beat(0, 1, 1, 10);
        chk("r_bv",  bv64, 64'h400);
        chk("r_num", 64'(num64), 64'd1);
        consume("r");

        // all 64 indices, descending
        for (int i = 63; i >= 0; i--)
            beat(0, i == 63, i == 0, i);
        chk("full_bv",  bv64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("full_num", 64'(num64), 64'd64);
        chk("full_err", 64'(err64), 64'd0);
`ifdef BV_GEN_LOWEST_EN
        chk("full_low", 64'(low64), 64'd0);
`endif
        consume("full");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
